// File: rtl/ext_hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bundle: issue request,
// source reads, and stall/bypass/writeback tag results.
interface ext_hazard_scoreboard_if #(
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int MAX_LAT = 4
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic             issue_vld;
  logic             issue_we;
  logic [AW-1:0]    issue_dst;
  logic [LAT_W-1:0] issue_lat;
  logic             flush;
  logic [NRD-1:0]   rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic             stall;
  logic [NRD-1:0]   byp;
  logic             wb_vld;
  logic [AW-1:0]    wb_dst;
  logic             busy;
  logic             lat_err;

  modport master (
    output issue_vld, issue_we, issue_dst,
    output issue_lat, flush, rd_en, rd_addr,
    input  stall, byp, wb_vld, wb_dst,
    input  busy, lat_err
  );

  modport slave (
    input  issue_vld, issue_we, issue_dst,
    input  issue_lat, flush, rd_en, rd_addr,
    output stall, byp, wb_vld, wb_dst,
    output busy, lat_err
  );
endinterface

// File: rtl/ext_hazard_scoreboard.sv
// Variable-latency hazard/bypass scoreboard for ID:
// a writeback-slot shift pipeline of in-flight results.
module ext_hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int MAX_LAT = 4
) (
  input logic clk,
  input logic rst,
  ext_hazard_scoreboard_if.slave sb
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic [MAX_LAT-1:0] slot_vld;
  logic [AW-1:0]      slot_dst [MAX_LAT];
  logic               lat_err_q;

  logic           dst_live;
  logic           legal_lat;
  logic           waw;
  logic           st_hit;
  logic           stall_w;
  logic           accept;
  logic           alloc;
  logic [NRD-1:0] raw;
  logic [NRD-1:0] hit0;

  // Slot k in [lo,hi] holds a live result for r (r0 never matches)
  function automatic logic in_slots(
    input logic [AW-1:0] r,
    input int            lo,
    input int            hi
  );
    in_slots = 1'b0;
    for (int k = lo; k <= hi; k++)
      if (slot_vld[k] && slot_dst[k] == r && r != '0)
        in_slots = 1'b1;
  endfunction

  always_comb begin
    dst_live  = sb.issue_we && (sb.issue_dst != '0);
    legal_lat = (sb.issue_lat != '0) &&
                (sb.issue_lat <= LAT_W'(MAX_LAT));
    waw = sb.issue_vld && sb.issue_we &&
          in_slots(sb.issue_dst, 1, MAX_LAT - 1);
    st_hit = 1'b0;
    for (int k = 0; k < MAX_LAT; k++)
      if (slot_vld[k] && sb.issue_lat == LAT_W'(k))
        st_hit = 1'b1;
    st_hit = st_hit && sb.issue_vld && dst_live;
    raw  = '0;
    hit0 = '0;
    for (int i = 0; i < NRD; i++) begin
      raw[i]  = sb.rd_en[i] &&
                in_slots(sb.rd_addr[i*AW +: AW], 1, MAX_LAT - 1);
      hit0[i] = sb.rd_en[i] &&
                in_slots(sb.rd_addr[i*AW +: AW], 0, 0);
    end
    stall_w = !sb.flush && sb.issue_vld &&
              ((|raw) || waw || st_hit);
    accept  = sb.issue_vld && !stall_w && !sb.flush;
    alloc   = accept && dst_live && legal_lat;
  end

  assign sb.stall   = stall_w;
  assign sb.byp     = hit0 & {NRD{!stall_w}};
  assign sb.wb_vld  = slot_vld[0];
  assign sb.wb_dst  = slot_dst[0];
  assign sb.busy    = |slot_vld;
  assign sb.lat_err = lat_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld  <= '0;
      lat_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < MAX_LAT - 1; k++) begin
        slot_vld[k] <= slot_vld[k+1];
        slot_dst[k] <= slot_dst[k+1];
      end
      slot_vld[MAX_LAT-1] <= 1'b0;
      // New result overrides whatever shifted into its slot
      for (int k = 0; k < MAX_LAT; k++)
        if (alloc && sb.issue_lat == LAT_W'(k + 1)) begin
          slot_vld[k] <= 1'b1;
          slot_dst[k] <= sb.issue_dst;
        end
      if (accept && !legal_lat)
        lat_err_q <= 1'b1;
    end
  end
endmodule
